// File: rtl/apb2axi.sv
// APB3/APB4 completer to single-beat AXI4 manager bridge; PREADY is held low until the AXI response returns.
// Optional APB4 byte strobes: define APB2AXI_PSTRB_EN to add PSTRB and forward it to WSTRB.
module apb2axi #(
   parameter int unsigned APB_ADDR_WIDTH     = 32,
   parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
   parameter int unsigned AXI4_DATA_WIDTH    = 32,
   parameter int unsigned AXI4_ID_WIDTH      = 16,
   parameter int unsigned AXI4_USER_WIDTH    = 10,
   parameter int unsigned AXI_ID             = 0,
   parameter int unsigned AXI_NUMBYTES       = AXI4_DATA_WIDTH/8
) (
   input  logic                          ACLK,
   input  logic                          ARESETn,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   input  logic                          PWRITE,
   input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
   input  logic [AXI4_DATA_WIDTH-1:0]    PWDATA,
`ifdef APB2AXI_PSTRB_EN
   input  logic [AXI_NUMBYTES-1:0]       PSTRB,
`endif
   output logic [AXI4_DATA_WIDTH-1:0]    PRDATA,
   output logic                          PREADY,
   output logic                          PSLVERR,
   output logic                          AWVALID,
   input  logic                          AWREADY,
   output logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR,
   output logic [AXI4_ID_WIDTH-1:0]      AWID,
   output logic [7:0]                    AWLEN,
   output logic [2:0]                    AWSIZE,
   output logic [1:0]                    AWBURST,
   output logic                          AWLOCK,
   output logic [3:0]                    AWCACHE,
   output logic [2:0]                    AWPROT,
   output logic [3:0]                    AWREGION,
   output logic [3:0]                    AWQOS,
   output logic [AXI4_USER_WIDTH-1:0]    AWUSER,
   output logic                          WVALID,
   input  logic                          WREADY,
   output logic [AXI4_DATA_WIDTH-1:0]    WDATA,
   output logic [AXI_NUMBYTES-1:0]       WSTRB,
   output logic                          WLAST,
   output logic [AXI4_USER_WIDTH-1:0]    WUSER,
   input  logic                          BVALID,
   output logic                          BREADY,
   input  logic [1:0]                    BRESP,
   input  logic [AXI4_ID_WIDTH-1:0]      BID,
   input  logic [AXI4_USER_WIDTH-1:0]    BUSER,
   output logic                          ARVALID,
   input  logic                          ARREADY,
   output logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR,
   output logic [AXI4_ID_WIDTH-1:0]      ARID,
   output logic [7:0]                    ARLEN,
   output logic [2:0]                    ARSIZE,
   output logic [1:0]                    ARBURST,
   output logic                          ARLOCK,
   output logic [3:0]                    ARCACHE,
   output logic [2:0]                    ARPROT,
   output logic [3:0]                    ARREGION,
   output logic [3:0]                    ARQOS,
   output logic [AXI4_USER_WIDTH-1:0]    ARUSER,
   input  logic                          RVALID,
   output logic                          RREADY,
   input  logic [AXI4_DATA_WIDTH-1:0]    RDATA,
   input  logic [1:0]                    RRESP,
   input  logic                          RLAST,
   input  logic [AXI4_ID_WIDTH-1:0]      RID,
   input  logic [AXI4_USER_WIDTH-1:0]    RUSER
);

   // state   | meaning
   // IDLE    | waiting for an APB access phase
   // WR_REQ  | AW and W offered, each retired on its own handshake
   // WR_RESP | BREADY high, waiting for the write response
   // RD_REQ  | ARVALID high until ARREADY
   // RD_RESP | RREADY high, waiting for read data
   // DONE    | PREADY pulse, one cycle
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

   localparam logic [2:0] AX_SIZE = 3'($clog2(AXI_NUMBYTES));

   state_t                          state_q, state_d;
   logic                            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                            arvalid_q, arvalid_d, rready_q, rready_d;
   logic                            pready_q, pready_d, pslverr_q, pslverr_d;
   logic [AXI4_DATA_WIDTH-1:0]      prdata_q, prdata_d, wdata_q, wdata_d;
   logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [AXI4_ADDRESS_WIDTH-1:0]   paddr_axi;
`ifdef APB2AXI_PSTRB_EN
   logic [AXI_NUMBYTES-1:0]         wstrb_q, wstrb_d;
`endif

   generate
      if (APB_ADDR_WIDTH >= AXI4_ADDRESS_WIDTH) begin : g_addr_trunc
         assign paddr_axi = PADDR[AXI4_ADDRESS_WIDTH-1:0];
      end else begin : g_addr_ext
         assign paddr_axi = {{(AXI4_ADDRESS_WIDTH-APB_ADDR_WIDTH){1'b0}}, PADDR};
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      pready_d  = 1'b0;
      pslverr_d = pslverr_q;
      prdata_d  = prdata_q;
      wdata_d   = wdata_q;
      addr_d    = addr_q;
`ifdef APB2AXI_PSTRB_EN
      wstrb_d   = wstrb_q;
`endif
      case (state_q)
         IDLE: begin
            pslverr_d = 1'b0;
            if (PSEL && PENABLE) begin
               addr_d  = paddr_axi;
               wdata_d = PWDATA;
`ifdef APB2AXI_PSTRB_EN
               wstrb_d = PSTRB;
`endif
               if (PWRITE) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            // each channel retires independently; leave once both are gone
            awvalid_d = awvalid_q && !AWREADY;
            wvalid_d  = wvalid_q && !WREADY;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (BVALID) begin
               bready_d  = 1'b0;
               pslverr_d = BRESP[1];
               pready_d  = 1'b1;
               state_d   = DONE;
            end
         end
         RD_REQ: begin
            if (ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (RVALID) begin
               rready_d  = 1'b0;
               prdata_d  = RDATA;
               pslverr_d = RRESP[1];
               pready_d  = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            pslverr_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         wdata_q   <= '0;
         addr_q    <= '0;
`ifdef APB2AXI_PSTRB_EN
         wstrb_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         wdata_q   <= wdata_d;
         addr_q    <= addr_d;
`ifdef APB2AXI_PSTRB_EN
         wstrb_q   <= wstrb_d;
`endif
      end
   end

   assign PRDATA   = prdata_q;
   assign PREADY   = pready_q;
   assign PSLVERR  = pslverr_q;
   assign AWVALID  = awvalid_q;
   assign AWADDR   = addr_q;
   assign AWID     = AXI4_ID_WIDTH'(AXI_ID);
   assign AWLEN    = 8'd0;
   assign AWSIZE   = AX_SIZE;
   assign AWBURST  = 2'b01;
   assign AWLOCK   = 1'b0;
   assign AWCACHE  = 4'd0;
   assign AWPROT   = 3'd0;
   assign AWREGION = 4'd0;
   assign AWQOS    = 4'd0;
   assign AWUSER   = '0;
   assign WVALID   = wvalid_q;
   assign WDATA    = wdata_q;
`ifdef APB2AXI_PSTRB_EN
   assign WSTRB    = wstrb_q;
`else
   assign WSTRB    = '1;
`endif
   assign WLAST    = 1'b1;
   assign WUSER    = '0;
   assign BREADY   = bready_q;
   assign ARVALID  = arvalid_q;
   assign ARADDR   = addr_q;
   assign ARID     = AXI4_ID_WIDTH'(AXI_ID);
   assign ARLEN    = 8'd0;
   assign ARSIZE   = AX_SIZE;
   assign ARBURST  = 2'b01;
   assign ARLOCK   = 1'b0;
   assign ARCACHE  = 4'd0;
   assign ARPROT   = 3'd0;
   assign ARREGION = 4'd0;
   assign ARQOS    = 4'd0;
   assign ARUSER   = '0;
   assign RREADY   = rready_q;

   // single outstanding transaction, so IDs, user bits and RLAST carry no information
   logic unused_ok;
   assign unused_ok = ^{BID, BUSER, RID, RUSER, RLAST, BRESP[0], RRESP[0], PADDR};

endmodule

// File: tb/tb_apb2axi.sv
// Directed bench for apb2axi: scripted APB accesses against a latency-configurable AXI responder,
// expected APB results queued at issue and compared when PREADY returns.
module tb_apb2axi;

   logic        ACLK, ARESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;
   logic        PREADY, PSLVERR;
   logic        AWVALID, AWREADY, AWLOCK, WVALID, WREADY, WLAST, BVALID, BREADY;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [15:0] AWID, ARID, BID, RID;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic [3:0]  AWCACHE, AWREGION, AWQOS, ARCACHE, ARREGION, ARQOS, WSTRB;
   logic [9:0]  AWUSER, WUSER, ARUSER, BUSER, RUSER;
   logic        ARVALID, ARREADY, ARLOCK, RVALID, RREADY, RLAST;

   apb2axi dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB2AXI_PSTRB_EN
      .PSTRB(PSTRB),
`endif
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
      .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
      .AWREGION(AWREGION), .AWQOS(AWQOS), .AWUSER(AWUSER),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID), .BUSER(BUSER),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
      .ARREGION(ARREGION), .ARQOS(ARQOS), .ARUSER(ARUSER),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RID(RID), .RUSER(RUSER)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   // responder knobs, written only by the main sequence
   int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
   logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
   logic [31:0] rdata_k = '0;

   // AXI responder: readies/valids change on the falling edge only
   initial begin
      int aw_w, w_w, b_w, ar_w, r_w;
      aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      BRESP = 0; RRESP = 0; RDATA = 0; RLAST = 1; BID = 0; RID = 0; BUSER = 0; RUSER = 0;
      forever begin
         @(negedge ACLK);
         AWREADY = AWVALID && (aw_w >= aw_lat); aw_w = AWVALID ? aw_w + 1 : 0;
         WREADY  = WVALID  && (w_w  >= w_lat);  w_w  = WVALID  ? w_w + 1  : 0;
         ARREADY = ARVALID && (ar_w >= ar_lat); ar_w = ARVALID ? ar_w + 1 : 0;
         BVALID  = BREADY  && (b_w  >= b_lat);  b_w  = BREADY  ? b_w + 1  : 0;
         RVALID  = RREADY  && (r_w  >= r_lat);  r_w  = RREADY  ? r_w + 1  : 0;
         BRESP = bresp_k; RRESP = rresp_k; RDATA = rdata_k;
      end
   end

   // handshake / activity monitor
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
   int aw_vc = 0, w_vc = 0, rr_c = 0, pr_c = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0]  cap_wstrb = '0;
   always @(posedge ACLK) begin
      if (AWVALID) aw_vc <= aw_vc + 1;
      if (WVALID) w_vc <= w_vc + 1;
      if (RREADY) rr_c <= rr_c + 1;
      if (PREADY) pr_c <= pr_c + 1;
      if (AWVALID && AWREADY) begin aw_hs <= aw_hs + 1; cap_awaddr <= AWADDR; end
      if (WVALID && WREADY) begin w_hs <= w_hs + 1; cap_wdata <= WDATA; cap_wstrb <= WSTRB; end
      if (BVALID && BREADY) b_hs <= b_hs + 1;
      if (ARVALID && ARREADY) begin ar_hs <= ar_hs + 1; cap_araddr <= ARADDR; end
      if (RVALID && RREADY) r_hs <= r_hs + 1;
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];
   logic [31:0] last_rdata = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_strb(input logic [3:0] s);
`ifdef APB2AXI_PSTRB_EN
      return s;
`else
      return 4'hF & {4{s[0] | ~s[0]}};
`endif
   endfunction

   task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] rdata, input logic err,
                           input int cyc);
      exp_t e;
      int   n;
      bit   got;
      e.wr = wr; e.addr = addr; e.wdata = wdata; e.strb = exp_strb(strb);
      e.rdata = wr ? last_rdata : rdata; e.err = err; e.cyc = cyc;
      if (!wr) last_rdata = rdata;
      sb.push_back(e);
      @(negedge ACLK);
      PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
      @(negedge ACLK);
      PENABLE = 1;
      n = 0; got = 0;
      while (n < 60 && !got) begin
         @(posedge ACLK); #1;
         n++;
         got = PREADY;
      end
      check("pready_timeout", 64'(got), 64'(1));
      if (got && sb.size() > 0) begin
         e = sb.pop_front();
         check("access_cycle", 64'(n + 1), 64'(e.cyc));
         check("pslverr", 64'(PSLVERR), 64'(e.err));
         check("prdata", 64'(PRDATA), 64'(e.rdata));
         if (e.wr) begin
            check("awaddr", 64'(cap_awaddr), 64'(e.addr));
            check("wdata", 64'(cap_wdata), 64'(e.wdata));
            check("wstrb", 64'(cap_wstrb), 64'(e.strb));
         end else begin
            check("araddr", 64'(cap_araddr), 64'(e.addr));
         end
      end
      @(negedge ACLK);
      PSEL = 0; PENABLE = 0;
      @(posedge ACLK); #1;
      check("pready_one_cycle", 64'(PREADY), 64'(0));
      check("pslverr_cleared", 64'(PSLVERR), 64'(0));
   endtask

   initial begin
      int a0, w0, b0, ar0, r0, av0, wv0, rr0, pr0;
      bit got;
      ARESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; PSTRB = 0;
      repeat (3) @(posedge ACLK);
      #1;
      check("rst_awvalid", 64'(AWVALID), 64'(0));
      check("rst_wvalid", 64'(WVALID), 64'(0));
      check("rst_arvalid", 64'(ARVALID), 64'(0));
      check("rst_bready", 64'(BREADY), 64'(0));
      check("rst_rready", 64'(RREADY), 64'(0));
      check("rst_pready", 64'(PREADY), 64'(0));
      check("rst_pslverr", 64'(PSLVERR), 64'(0));
      check("rst_prdata", 64'(PRDATA), 64'(0));
      check("const_awlen", 64'(AWLEN), 64'(0));
      check("const_awsize", 64'(AWSIZE), 64'(2));
      check("const_arburst", 64'(ARBURST), 64'(1));
      check("const_wlast", 64'(WLAST), 64'(1));
      @(negedge ACLK) ARESETn = 1;

      // write, everything ready: 3 wait states
      a0 = aw_hs; w0 = w_hs; b0 = b_hs; av0 = aw_vc; wv0 = w_vc; pr0 = pr_c;
      apb_xfer(1, 32'h40, 32'hDEADBEEF, 4'hF, '0, 0, 4);
      check("wr1_aw_hs", 64'(aw_hs - a0), 64'(1));
      check("wr1_w_hs", 64'(w_hs - w0), 64'(1));
      check("wr1_b_hs", 64'(b_hs - b0), 64'(1));
      check("wr1_aw_cycles", 64'(aw_vc - av0), 64'(1));
      check("wr1_w_cycles", 64'(wv0 - w_vc + 2 * (w_vc - wv0)), 64'(1));
      check("wr1_pready_cycles", 64'(pr_c - pr0), 64'(1));

      // read with RVALID five cycles into RD_RESP
      r_lat = 5; rdata_k = 32'h12345678;
      ar0 = ar_hs; r0 = r_hs; rr0 = rr_c; pr0 = pr_c;
      apb_xfer(0, 32'h80, '0, 4'h0, 32'h12345678, 0, 9);
      check("rd1_ar_hs", 64'(ar_hs - ar0), 64'(1));
      check("rd1_r_hs", 64'(r_hs - r0), 64'(1));
      check("rd1_rready_cycles", 64'(rr_c - rr0), 64'(6));
      check("rd1_pready_cycles", 64'(pr_c - pr0), 64'(1));
      r_lat = 0;

      // W accepted three cycles after AW
      w_lat = 3;
      b0 = b_hs; av0 = aw_vc; wv0 = w_vc; pr0 = pr_c;
      apb_xfer(1, 32'h44, 32'hA5A50001, 4'hF, '0, 0, 7);
      check("wr2_aw_cycles", 64'(aw_vc - av0), 64'(1));
      check("wr2_w_cycles", 64'(w_vc - wv0), 64'(4));
      check("wr2_b_hs", 64'(b_hs - b0), 64'(1));
      check("wr2_pready_cycles", 64'(pr_c - pr0), 64'(1));
      w_lat = 0;

      // error responses, then a clean read
      bresp_k = 2'b10;
      apb_xfer(1, 32'h48, 32'h00000077, 4'hF, '0, 1, 4);
      bresp_k = 2'b00; rresp_k = 2'b11; rdata_k = 32'hCAFE0000;
      apb_xfer(0, 32'h8C, '0, 4'h0, 32'hCAFE0000, 1, 4);
      rresp_k = 2'b00; rdata_k = 32'h0BADF00D;
      apb_xfer(0, 32'h90, '0, 4'h0, 32'h0BADF00D, 0, 4);

      // reset while waiting in RD_RESP
      r_lat = 20;
      @(negedge ACLK);
      PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'hA0;
      @(negedge ACLK);
      PENABLE = 1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge ACLK); #1;
         got = RREADY;
      end
      check("rst_reach_rd_resp", 64'(got), 64'(1));
      @(negedge ACLK);
      ARESETn = 0; PSEL = 0; PENABLE = 0;
      #1;
      check("midrst_rready", 64'(RREADY), 64'(0));
      check("midrst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY}), 64'(0));
      check("midrst_pready", 64'(PREADY), 64'(0));
      check("midrst_prdata", 64'(PRDATA), 64'(0));
      @(negedge ACLK) ARESETn = 1;
      last_rdata = '0;
      r_lat = 0; rdata_k = 32'h55AA55AA;
      apb_xfer(0, 32'hA4, '0, 4'h0, 32'h55AA55AA, 0, 4);

      // byte strobes with an unaligned address
      apb_xfer(1, 32'h43, 32'h11223344, 4'b0101, '0, 0, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
